// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with memory handshake, wait timeout and sticky fault
// Inputs:  clk, reset (async, active-high), op/funct (IR fields), zero (ALU flag), memready (access done).
// Outputs: memory strobes (memreq, memwrite, iord), datapath selects and enables,
//          alucontrol, fault (sticky until reset) and state (debug).
module mc_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNTW = 8,
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memready,
  output logic             memreq,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             regwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             signext,
  output logic             shiftl16,
  output logic [ALUCW-1:0] alucontrol,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             fault,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE, S_RTWB,
    S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] F_JR = 6'b001000;
  localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(4'b0100), ALU_SUB = ALUCW'(4'b1100);
  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(4'b0000), ALU_OR = ALUCW'(4'b0010);
  localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(4'b1110), ALU_SLTU = ALUCW'(4'b1111);
  state_t st, dnext;
  logic [CNTW-1:0] cnt;
  logic memst, tmo, rt_ok;
  logic [ALUCW-1:0] rt_alu, imm_alu;
  assign memst = st inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign tmo = (TIMEOUT != 0) && (cnt == CNTW'(TIMEOUT));
  assign rt_ok = funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU};
  always_comb begin
    dnext = (op == OP_LW || op == OP_SW) ? S_MEMADR :
            (op == OP_R) ? ((funct == F_JR) ? S_JR : rt_ok ? S_RTYPE : S_FAULT) :
            (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
            (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ORI, OP_LUI}) ? S_IMMEX :
            (op == OP_J) ? S_JUMP :
            (op == OP_JAL) ? S_JAL : S_FAULT;
    rt_alu = (funct == F_SUB || funct == F_SUBU) ? ALU_SUB :
             (funct == F_AND) ? ALU_AND :
             (funct == F_OR) ? ALU_OR :
             (funct == F_SLT) ? ALU_SLT :
             (funct == F_SLTU) ? ALU_SLTU : ALU_ADD;
    imm_alu = (op == OP_SLTI) ? ALU_SLT : (op == OP_ORI) ? ALU_OR : ALU_ADD;
  end
  // The wait counter only runs while a stalled access is pending; a completing
  // access wins over an expiring timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= S_FETCH;
      cnt <= '0;
    end else begin
      cnt <= (memready || !memst) ? '0 : cnt + 1'b1;
      if (memst && !memready && tmo) st <= S_FAULT;
      else
        case (st)
          S_FETCH:  if (memready) st <= S_DECODE;
          S_DECODE: st <= dnext;
          S_MEMADR: st <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
          S_MEMRD:  if (memready) st <= S_MEMWB;
          S_MEMWR:  if (memready) st <= S_FETCH;
          S_RTYPE:  st <= S_RTWB;
          S_IMMEX:  st <= S_IMMWB;
          S_FAULT:  st <= S_FAULT;
          default:  st <= S_FETCH;
        endcase
    end
  end
  assign state = st;
  assign memreq = memst;
  assign memwrite = st == S_MEMWR;
  assign iord = st == S_MEMRD || st == S_MEMWR;
  assign irwrite = st == S_FETCH && memready && !reset;
  assign regwrite = st inside {S_MEMWB, S_RTWB, S_IMMWB, S_JAL};
  assign regdst = (st == S_RTWB) ? 2'b01 : (st == S_JAL) ? 2'b10 : 2'b00;
  assign memtoreg = (st == S_MEMWB) ? 2'b01 : (st == S_JAL) ? 2'b10 : 2'b00;
  assign alusrca = st inside {S_MEMADR, S_RTYPE, S_IMMEX, S_BRANCH};
  assign alusrcb = (st == S_FETCH) ? 2'b01 : (st == S_DECODE) ? 2'b11 :
                   (st == S_MEMADR || st == S_IMMEX) ? 2'b10 : 2'b00;
  assign signext = !(st == S_IMMEX && op == OP_ORI);
  assign shiftl16 = st == S_IMMEX && op == OP_LUI;
  assign alucontrol = (st == S_BRANCH) ? ALU_SUB : (st == S_RTYPE) ? rt_alu :
                      (st == S_IMMEX) ? imm_alu : ALU_ADD;
  assign pcsrc = (st == S_BRANCH) ? 2'b01 : (st == S_JUMP || st == S_JAL) ? 2'b10 :
                 (st == S_JR) ? 2'b11 : 2'b00;
  // op[0] separates BNE from BEQ, so the branch is taken when zero differs from it.
  assign pcen = !reset && ((st == S_FETCH && memready) || (st == S_BRANCH && (zero ^ op[0])) ||
                           st == S_JUMP || st == S_JAL || st == S_JR);
  assign fault = st == S_FAULT;
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the MIPS core; the next generation of the single-cycle controller.
- Sequences each instruction over 3-5 states in a shared datapath: one ALU, unified instruction/data memory, IR/MDR/A/B/ALUOut registers.
- Adds a variable-latency memory handshake (memreq/memready) with a parametrised wait timeout.
- Traps illegal opcodes/functs into a sticky fault state.
- Instruction set: R-type (ADD/ADDU/SUB/SUBU/AND/OR/SLT/SLTU/JR), LW, SW, BEQ, BNE, ADDI, ADDIU, SLTI, ORI, LUI, J, JAL.

Parameters:
- TIMEOUT, 255, maximum consecutive memready=0 cycles tolerated while memreq=1 before entering FAULT; 0 disables the timeout.
- CNTW, 8, wait-counter width; must satisfy 2^CNTW > TIMEOUT.
- ALUCW, 4, alucontrol width. Codes: 0100 add, 1100 sub, 0000 and, 0010 or, 1110 slt, 1111 sltu.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- memready  in  1  memory completes the current access this cycle.
- memreq  out  1  memory access request.
- memwrite  out  1  write strobe (valid only with memreq).
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load IR.
- regwrite  out  1  register-file write enable.
- regdst  out  2  write address: 00 rt, 01 rd, 10 $31.
- memtoreg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC.
- alusrca  out  1  ALU A source: 0 PC, 1 regA.
- alusrcb  out  2  ALU B source: 00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- signext  out  1  immediate extension: 1 sign, 0 zero.
- shiftl16  out  1  shift extended immediate left 16.
- alucontrol  out  ALUCW  ALU operation.
- pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 {PC[31:28], IR[25:0], 00}, 11 regA.
- pcen  out  1  PC write enable.
- fault  out  1  sticky error flag.
- state  out  4  current state, for debug.

Behaviour:
- Outputs are Moore decodes of state, except irwrite, pcen and the exit from wait states, which are qualified by memready/zero as stated below.
- Every enable not listed for a state is 0. alucontrol defaults to add; signext defaults to 1.

States:
- FETCH:
  - memreq=1, iord=0, alusrca=0, alusrcb=01.
  - On memready=1: irwrite=1, pcsrc=00, pcen=1, next state DECODE.
  - Otherwise stay in FETCH with irwrite=0 and pcen=0.
- DECODE:
  - alusrca=0, alusrcb=11, signext=1 (ALUOut <= branch target).
  - Next state by op: LW/SW -> MEMADR; R-type -> RTYPE, or JR if funct=001000; BEQ/BNE -> BRANCH; ADDI/ADDIU/SLTI/ORI/LUI -> IMMEX; J -> JUMP; JAL -> JAL; any other op or R-type funct -> FAULT.
- MEMADR:
  - alusrca=1, alusrcb=10, signext=1.
  - Next state MEMRD for LW, MEMWR for SW.
- MEMRD: memreq=1, iord=1; on memready go to MEMWB, else hold.
- MEMWB: regwrite=1, regdst=00, memtoreg=01; next FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1; on memready go to FETCH, else hold.
- RTYPE: alusrca=1, alusrcb=00, alucontrol per funct; next RTWB.
- RTWB: regwrite=1, regdst=01, memtoreg=00; next FETCH.
- IMMEX:
  - alusrca=1, alusrcb=10; next IMMWB.
  - ADDI/ADDIU: signext=1, add. SLTI: signext=1, slt. ORI: signext=0, or. LUI: shiftl16=1, add (A operand is $0 via rs).
- IMMWB: regwrite=1, regdst=00, memtoreg=00; next FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01.
  - pcen = zero XOR op[0], so BEQ takes on zero=1 and BNE takes on zero=0.
  - Next FETCH.
- JUMP: pcsrc=10, pcen=1; next FETCH.
- JAL:
  - pcsrc=10, pcen=1, regwrite=1, regdst=10, memtoreg=10.
  - Writes the already-incremented PC (PC+4) to $31; next FETCH.
- JR: pcsrc=11, pcen=1; next FETCH.
- FAULT:
  - fault=1, all enables 0, memreq=0.
  - Held until reset.

Cycle counts with memready=1 in every memory cycle:
- LW 5; SW, R-type and immediate ops 4; branch, J, JAL and JR 3.
- Each memory cycle adds one cycle per memready=0.

Wait counter:
- Clears whenever memready=1 or the state is not a memory state (FETCH/MEMRD/MEMWR).
- Increments each cycle with memreq=1 and memready=0.
- If TIMEOUT>0 and the counter equals TIMEOUT while memready=0 -> FAULT on the next edge.
- memready=1 in the same cycle as the timeout takes priority: the access completes normally.

Reset:
- Asynchronous: state=FETCH, counter=0, fault=0.
- Output values while in reset: memreq=1, iord=0, alusrcb=01, alucontrol=0100, all write enables 0 (pcen and irwrite forced 0 while reset=1).
- Reset asserted mid-access aborts the access immediately; no partial irwrite or regwrite occurs.

Test Plan:
- Reset, then ADD (op 000000, funct 100000) with memready always 1 -> states FETCH, DECODE, RTYPE, RTWB, FETCH; regwrite=1, regdst=01 only in RTWB; pcen=1 only in FETCH.
- LW with memready low for 3 cycles in MEMRD -> 8 cycles total; iord=1 and memreq=1 held throughout; regwrite=1, memtoreg=01 in MEMWB.
- BEQ with zero=1 -> pcen=1, pcsrc=01 in BRANCH; BNE with zero=1 -> pcen=0; BNE with zero=0 -> pcen=1.
- JAL -> 3 cycles; in the JAL state pcsrc=10, regdst=10, memtoreg=10, regwrite=1. JR (funct 001000) -> pcsrc=11, regwrite=0.
- TIMEOUT=4, memready held 0 in FETCH -> FAULT after 5 cycles, fault=1, memreq=0. Repeat with memready=1 on the 5th cycle -> no fault.
- Illegal op 111111 -> FAULT from DECODE. Async reset mid-MEMWR -> immediate FETCH, memwrite=0, fault=0.
